sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Sequences the external 16-bit asynchronous SRAM on behalf of the MEM pipeline stage.
- Converts each 32-bit load/store, qualified by MEM_R_EN/MEM_W_EN from the control path, into two 16-bit SRAM transfers, each lasting a fixed number of wait cycles.
- Drops `ready` while an access is in flight; the pipeline freezes all stage registers while `ready` is 0.

Parameters:
- WAIT_CYCLES, 2, clock cycles per 16-bit half transfer; legal range is >= 1.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  store request (MEM_W_EN).
- rd_en  input  1  load request (MEM_R_EN).
- address  input  32  CPU byte address.
- write_data  input  32  store data.
- read_data  output  32  load result.
- ready  output  1  1 = no access pending or access completing this cycle; 0 = stall pipeline.
- sram_addr  output  18  SRAM half-word address.
- sram_dq_in  input  16  SRAM data bus, read direction.
- sram_dq_out  output  16  SRAM data bus, write direction.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the pad.
- sram_ce_n  output  1  chip enable, active-low.
- sram_oe_n  output  1  output enable, active-low.
- sram_we_n  output  1  write enable, active-low.
- sram_ub_n  output  1  upper byte lane enable, active-low.
- sram_lb_n  output  1  lower byte lane enable, active-low.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Request decode: req = rd_en | wr_en.
  - If both are asserted, the access is a write (wr_en has priority).
- Address mapping: off = address - BASE_ADDR, modulo 2^32.
  - idx = off[18:2]; off[1:0] is ignored.
  - sram_addr = {idx, half}, where half = 0 selects bits [15:0] and half = 1 selects bits [31:16].
  - Out-of-range addresses wrap; no error is flagged.
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter `cnt` is sized for WAIT_CYCLES.
- IDLE:
  - If req: latch op, idx and write_data; cnt <= 0; go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - half = 0; cnt increments each cycle.
  - When cnt == WAIT_CYCLES-1: for a read, read_data[15:0] <= sram_dq_in; cnt <= 0; go to HIGH.
- HIGH:
  - Same as LOW with half = 1; for a read, captures read_data[31:16].
  - When cnt == WAIT_CYCLES-1, go to DONE.
- DONE: go to IDLE unconditionally.
- ready (combinational):
  - 1 in IDLE when req = 0, and 1 in DONE.
  - 0 in every other case, including IDLE with req = 1.
- Latency: the request is seen in IDLE at cycle 0.
  - LOW occupies cycles 1..W; HIGH occupies W+1..2W; DONE with ready = 1 is cycle 2W+1.
  - ready is therefore 0 for 2W+1 cycles; for W = 2 that is 5 stall cycles.
- SRAM strobes during LOW and HIGH (active = state is LOW or HIGH):
  - sram_ce_n = 0; sram_ub_n = sram_lb_n = 0.
  - Read: sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - Write: sram_we_n = 0, sram_oe_n = 1, sram_dq_oe = 1; sram_dq_out = the latched half selected by `half`.
- SRAM strobes in IDLE and DONE:
  - ce_n, oe_n, we_n, ub_n and lb_n are all 1.
  - sram_dq_oe = 0; sram_dq_out = 0; sram_addr holds its last value (0 after reset).
- Input changes mid-access: changes to address, write_data, rd_en or wr_en after latching are ignored; a started access always completes.
- Back-to-back: if req is still asserted in IDLE after DONE, a new access starts; there is no idle gap beyond that IDLE cycle.
- read_data:
  - Updated only by read captures; writes leave it unchanged.
  - Holds its value between accesses.
  - During a read it is briefly mixed: the new low half with the old high half until HIGH completes. Consumers sample it only when ready = 1 in DONE.
- Reset (rst = 1 at any edge, including mid-access):
  - Next state IDLE, cnt = 0, read_data = 0, latched registers = 0, sram_addr = 0.
  - All active-low strobes go to 1 and sram_dq_oe to 0 in the cycle after the edge.
  - ready then follows the IDLE rule.

Test Plan:
- Idle: rd_en = wr_en = 0 for 10 cycles -> ready = 1; ce_n = we_n = oe_n = 1; sram_dq_oe = 0; read_data unchanged.
- Write, W = 2: wr_en = 1, address = 1024, write_data = 0xDEADBEEF ->
  - cycles 1-2: sram_addr = 0x00000, dq_out = 0xBEEF, we_n = 0, dq_oe = 1.
  - cycles 3-4: sram_addr = 0x00001, dq_out = 0xDEAD.
  - cycle 5: ready = 1; ready = 0 in cycles 0-4.
- Read: rd_en = 1, address = 1028; SRAM model returns 0x1234 at address 0x00002 and 0xABCD at 0x00003 ->
  - oe_n = 0 and we_n = 1 in cycles 1-4.
  - read_data = 0xABCD1234 with ready = 1 at cycle 5.
- Priority and latching: rd_en = wr_en = 1, address = 1032, data = 0x00FF00FF, then address changed to 2000 at cycle 2 -> write to SRAM addresses 0x00004/0x00005 with 0x00FF/0x00FF; read_data not modified.
- Back-to-back: rd_en held high for two reads (1024, then 1028) -> second LOW phase begins the cycle after the IDLE following DONE; both results correct; ready pulses high exactly once per access.
- Reset mid-write: rst = 1 at cycle 3 of a write -> next cycle: state IDLE, we_n = 1, ce_n = 1, dq_oe = 0, read_data = 0; with req = 0, ready = 1.

Source files
------------

// File: rtl/sram_controller.sv
// Sequences a 16-bit asynchronous SRAM for the MEM stage.
// Each 32-bit access becomes a low-half then a high-half transfer of WAIT_CYCLES each.
module sram_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int             CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [31:0]       wdata;
  logic [17:0]       addr_q;
  logic              req;
  logic              active;
  logic              last;
  logic [31:0]       off;
  logic              unused_off;

  assign req        = rd_en | wr_en;
  assign off        = address - BASE_ADDR;
  assign unused_off = ^{off[31:19], off[1:0]};
  assign active     = (state == LOW) || (state == HIGH);
  assign last       = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_next = LOW;
        else     ready      = 1'b1;
      end
      LOW:  if (last) state_next = HIGH;
      HIGH: if (last) state_next = DONE;
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // addr_q[0] is the half select; it stays at 1 after an access so the address holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      wdata     <= '0;
      addr_q    <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr  <= wr_en;
            wdata  <= write_data;
            addr_q <= {off[18:2], 1'b0};
            cnt    <= '0;
          end
        end
        LOW: begin
          if (last) begin
            cnt       <= '0;
            addr_q[0] <= 1'b1;
            if (!op_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (last) begin
            cnt <= '0;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign sram_addr   = addr_q;
  assign sram_ce_n   = ~active;
  assign sram_ub_n   = ~active;
  assign sram_lb_n   = ~active;
  assign sram_oe_n   = ~(active & ~op_wr);
  assign sram_we_n   = ~(active & op_wr);
  assign sram_dq_oe  = active & op_wr;
  assign sram_dq_out = sram_dq_oe ? (addr_q[0] ? wdata[31:16] : wdata[15:0]) : 16'h0000;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM behavioural model, per-cycle strobe checks,
// and a scoreboard of expected read_data popped on each completion pulse.
module tb_sram_controller;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in, sram_dq_out;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int          nchecks = 0;
  int          nerr = 0;
  int          done_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_read = '0;
  logic        ready_q = 1'b1;
  logic        rst_q = 1'b1;
  logic [15:0] mem [0:63];

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // A completion is ready rising out of an access, not out of reset.
  always @(negedge clk) begin
    if (ready === 1'b1 && ready_q === 1'b0 && !rst_q) begin
      done_cnt++;
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("read_data_done", read_data, sb_q.pop_front());
    end
    ready_q <= ready;
    rst_q   <= rst;
  end

  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] a_late, input bit keep, input logic [31:0] exp_rd);
    logic [31:0] off;
    logic [16:0] idx;
    off = a - BASE;
    idx = off[18:2];
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    if (!wr) last_read = exp_rd;
    sb_q.push_back(last_read);
    for (int c = 0; c <= 2*W+1; c++) begin
      @(negedge clk);
      check($sformatf("ready_c%0d", c), 32'(ready), 32'(c == 2*W+1));
      if (c >= 1 && c <= 2*W) begin
        check($sformatf("ce_n_c%0d", c), 32'(sram_ce_n), 32'd0);
        check($sformatf("ublb_c%0d", c), 32'({sram_ub_n, sram_lb_n}), 32'd0);
        check($sformatf("addr_c%0d", c), 32'(sram_addr), 32'({idx, 1'(c > W)}));
        check($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(!wr));
        check($sformatf("oe_n_c%0d", c), 32'(sram_oe_n), 32'(wr));
        check($sformatf("dq_oe_c%0d", c), 32'(sram_dq_oe), 32'(wr));
        if (wr) check($sformatf("dq_out_c%0d", c), 32'(sram_dq_out),
                      32'((c > W) ? d[31:16] : d[15:0]));
      end else begin
        check($sformatf("ce_n_c%0d", c), 32'(sram_ce_n), 32'd1);
        check($sformatf("dq_oe_c%0d", c), 32'(sram_dq_oe), 32'd0);
      end
      @(posedge clk); #1;
      if (c == 1) address = a_late;
      if (c == 2*W && !keep) begin wr_en = 1'b0; rd_en = 1'b0; end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[2] = 16'h1234;
    mem[3] = 16'hABCD;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'h7);
      check("idle_dq_oe", 32'(sram_dq_oe), 32'd0);
      check("idle_read_data", read_data, 32'd0);
    end
    @(posedge clk); #1;

    // Write 0xDEADBEEF to 1024
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd1024, 1'b0, 32'd0);
    check("mem0", 32'(mem[0]), 32'h0000BEEF);
    check("mem1", 32'(mem[1]), 32'h0000DEAD);

    // Read 1028
    access(1'b0, 1'b1, 32'd1028, 32'd0, 32'd1028, 1'b0, 32'hABCD1234);

    // Write priority with address changed mid-access
    access(1'b1, 1'b1, 32'd1032, 32'h00FF00FF, 32'd2000, 1'b0, 32'd0);
    check("mem4", 32'(mem[4]), 32'h000000FF);
    check("mem5", 32'(mem[5]), 32'h000000FF);
    check("prio_read_data", read_data, 32'hABCD1234);

    // Back-to-back reads with rd_en held
    access(1'b0, 1'b1, 32'd1024, 32'd0, 32'd1028, 1'b1, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1028, 32'd0, 32'd1028, 1'b0, 32'hABCD1234);
    check("b2b_done_cnt", 32'(done_cnt), 32'd5);

    // Reset in cycle 3 of a write
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    last_read = 32'd0;
    @(posedge clk); #1;

    // Recovery read after reset
    access(1'b0, 1'b1, 32'd1028, 32'd0, 32'd1028, 1'b0, 32'hABCD1234);
    repeat (2) @(posedge clk);
    check("final_done_cnt", 32'(done_cnt), 32'd6);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
